multibyte_add_sequencer: RTL

- Multi-cycle controller that drives one shared 8-bit full adder one byte per cycle, LSB first, with a registered carry between bytes.
- Performs NBYTES-wide add or subtract (two's complement), optionally chained through an external carry/borrow.
- Sits between the ALU decode logic and the 8-bit adder instance. The adder stays purely combinational; this block owns all sequencing state.

---
 rtl/multibyte_add_sequencer.sv | 85 ++++++++
 1 files changed

// File: rtl/multibyte_add_sequencer.sv
// multibyte_add_sequencer: byte-serial NBYTES-wide add/subtract over one shared external 8-bit adder
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   start, op, use_cin, cin    request, 0=add/1=sub, take initial carry from cin, external carry/not-borrow
//   a, b                       W-bit operands, sampled on the accept edge
//   add_a, add_b, add_cin      byte and carry driven to the adder (zero outside RUN)
//   add_s, add_cout            combinational adder result
//   ready, busy, done          IDLE / RUN-or-DONE / one-cycle result-valid pulse
//   s, cout, ovf, zero         registered result, final carry (1 = no borrow on sub), signed overflow, s == 0
module multibyte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op,
  input  logic                use_cin,
  input  logic                cin,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_cin,
  input  logic [7:0]          add_s,
  input  logic                add_cout,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] s,
  output logic                cout,
  output logic                ovf,
  output logic                zero
);
  localparam int W  = 8 * NBYTES;
  localparam int KW = $clog2(NBYTES);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0]  a_r, b_r;
  logic [KW-1:0] k;
  logic          carry, run, last, accept;
  always_comb begin
    run      = state == ST_RUN;
    last     = run && (k == KW'(NBYTES - 1));
    accept   = (state == ST_IDLE) && start;
    ready    = state == ST_IDLE;
    busy     = state != ST_IDLE;
    done     = state == ST_DONE;
    add_a    = run ? a_r[8*k +: 8] : 8'h00;
    add_b    = run ? b_r[8*k +: 8] : 8'h00;
    add_cin  = run ? carry : 1'b0;
    state_nx = accept ? ST_RUN : last ? ST_DONE : done ? ST_IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      k     <= '0;
      carry <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        // subtract is A + ~B + 1, so the inverted B and the initial carry are set up here
        a_r   <= a;
        b_r   <= op ? ~b : b;
        carry <= use_cin ? cin : op;
        k     <= '0;
      end else if (run) begin
        s[8*k +: 8] <= add_s;
        carry       <= add_cout;
        k           <= last ? '0 : k + 1'b1;
        if (last) begin
          cout <= add_cout;
          // a7^b7^s7 recovers the carry into bit 7, which the adder does not expose
          ovf  <= add_a[7] ^ add_b[7] ^ add_s[7] ^ add_cout;
          zero <= (add_s == 8'h00) && (s[W-9:0] == '0);
        end
      end
    end
  end
endmodule
